// File: rtl/mixer_reg_arbiter.sv
// Arbiter sequencing MIDI-decoder writes and host reads/writes onto the mixer register file.
// Optional patch-name dump reader (com bank 16..31) is built when MIXER_ARB_DUMP_EN is defined.
module mixer_reg_arbiter (
  input  logic       reg_clk,
  input  logic       reset,
  input  logic       midi_req,
  input  logic [1:0] midi_bank,
  input  logic [6:0] midi_adr,
  input  logic [7:0] midi_data,
  output logic       midi_busy,
  output logic       midi_ovf,
  input  logic       host_req,
  input  logic       host_wr,
  input  logic [1:0] host_bank,
  input  logic [6:0] host_adr,
  input  logic [7:0] host_wdata,
  output logic       host_ack,
  output logic [7:0] host_rdata,
  output logic [6:0] adr,
  output logic       write,
  output logic       read,
  output logic       osc_sel,
  output logic       com_sel,
  output logic       m1_sel,
  output logic       m2_sel,
  output logic [7:0] synth_data_out,
  input  logic [7:0] mixer_regdata_out,
  input  logic       dump_start,
  output logic       dump_valid,
  output logic [7:0] dump_data,
  output logic       dump_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR     = 3'd1,
    S_RD     = 3'd2,
    S_RD_CAP = 3'd3
`ifdef MIXER_ARB_DUMP_EN
    , S_DUMP_RD  = 3'd4
    , S_DUMP_CAP = 3'd5
`endif
  } state_t;

  state_t     state_q;
  logic       midi_busy_q;
  logic [1:0] midi_bank_q;
  logic [6:0] midi_adr_q;
  logic [7:0] midi_data_q;
  logic       midi_ovf_q;
  logic       prefer_host_q;
  logic       gnt_host_q;
  logic [6:0] adr_q;
  logic       write_q;
  logic       read_q;
  logic [3:0] sel_q;
  logic [7:0] wdata_q;
  logic       host_ack_q;
  logic [7:0] host_rdata_q;

  logic host_pend_s;
  logic midi_pend_s;
  logic pick_host_s;
  logic pick_midi_s;
  logic midi_drain_s;
  logic midi_accept_s;
  logic midi_drop_s;

  // Bank code to one-hot select: bit0 osc, bit1 com, bit2 m1, bit3 m2.
  function automatic logic [3:0] bank_onehot(input logic [1:0] bank);
    logic [3:0] oh;
    case (bank)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      2'd3:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

  // Request qualification, round-robin pick and MIDI buffer accept/drop decisions.
  always_comb begin
    // The host still holds host_req during its own ack cycle; that level is stale.
    host_pend_s   = host_req && !host_ack_q;
    midi_pend_s   = midi_busy_q;
    pick_host_s   = host_pend_s && (!midi_pend_s || prefer_host_q);
    pick_midi_s   = midi_pend_s && !pick_host_s;
    midi_drain_s  = (state_q == S_WR) && !gnt_host_q;
    midi_accept_s = midi_req && (!midi_busy_q || midi_drain_s);
    midi_drop_s   = midi_req && midi_busy_q && !midi_drain_s;
  end

`ifdef MIXER_ARB_DUMP_EN
  logic       dump_active_q;
  logic [3:0] dump_idx_q;
  logic       dump_valid_q;
  logic [7:0] dump_data_q;
  logic       dump_done_q;
  logic       pick_dump_s;

  // Dump only uses slots nobody else wants.
  always_comb begin
    pick_dump_s = dump_active_q && !host_pend_s && !midi_pend_s;
  end
`endif

  // Main sequencer: MIDI buffer, arbitration FSM and all registered outputs.
  always_ff @(posedge reg_clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      midi_busy_q   <= 1'b0;
      midi_bank_q   <= 2'd0;
      midi_adr_q    <= 7'd0;
      midi_data_q   <= 8'd0;
      midi_ovf_q    <= 1'b0;
      prefer_host_q <= 1'b1;
      gnt_host_q    <= 1'b0;
      adr_q         <= 7'd0;
      write_q       <= 1'b0;
      read_q        <= 1'b0;
      sel_q         <= 4'd0;
      wdata_q       <= 8'd0;
      host_ack_q    <= 1'b0;
      host_rdata_q  <= 8'd0;
`ifdef MIXER_ARB_DUMP_EN
      dump_active_q <= 1'b0;
      dump_idx_q    <= 4'd0;
      dump_valid_q  <= 1'b0;
      dump_data_q   <= 8'd0;
      dump_done_q   <= 1'b0;
`endif
    end else begin
      write_q    <= 1'b0;
      read_q     <= 1'b0;
      sel_q      <= 4'd0;
      host_ack_q <= 1'b0;
`ifdef MIXER_ARB_DUMP_EN
      dump_valid_q <= 1'b0;
      dump_done_q  <= 1'b0;
      if ((state_q == S_IDLE) && !dump_active_q && dump_start) begin
        dump_active_q <= 1'b1;
        dump_idx_q    <= 4'd0;
      end
`endif
      if (midi_accept_s) begin
        midi_busy_q <= 1'b1;
        midi_bank_q <= midi_bank;
        midi_adr_q  <= midi_adr;
        midi_data_q <= midi_data;
      end else if (midi_drain_s) begin
        midi_busy_q <= 1'b0;
      end
      if (midi_drop_s) begin
        midi_ovf_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (pick_host_s) begin
            gnt_host_q    <= 1'b1;
            prefer_host_q <= 1'b0;
            adr_q         <= host_adr;
            sel_q         <= bank_onehot(host_bank);
            wdata_q       <= host_wdata;
            write_q       <= host_wr;
            read_q        <= !host_wr;
            state_q       <= host_wr ? S_WR : S_RD;
          end else if (pick_midi_s) begin
            gnt_host_q    <= 1'b0;
            prefer_host_q <= 1'b1;
            adr_q         <= midi_adr_q;
            sel_q         <= bank_onehot(midi_bank_q);
            wdata_q       <= midi_data_q;
            write_q       <= 1'b1;
            state_q       <= S_WR;
`ifdef MIXER_ARB_DUMP_EN
          end else if (pick_dump_s) begin
            adr_q   <= {3'b001, dump_idx_q};
            sel_q   <= 4'b0010;
            read_q  <= 1'b1;
            state_q <= S_DUMP_RD;
`endif
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WR: begin
          host_ack_q <= gnt_host_q;
          state_q    <= S_IDLE;
        end
        S_RD: begin
          host_rdata_q <= mixer_regdata_out;
          host_ack_q   <= 1'b1;
          state_q      <= S_RD_CAP;
        end
        S_RD_CAP: begin
          state_q <= S_IDLE;
        end
`ifdef MIXER_ARB_DUMP_EN
        S_DUMP_RD: begin
          dump_data_q  <= mixer_regdata_out;
          dump_valid_q <= 1'b1;
          dump_done_q  <= (dump_idx_q == 4'd15);
          if (dump_idx_q == 4'd15) begin
            dump_active_q <= 1'b0;
          end
          dump_idx_q <= dump_idx_q + 4'd1;
          state_q    <= S_DUMP_CAP;
        end
        S_DUMP_CAP: begin
          state_q <= S_IDLE;
        end
`endif
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign midi_busy      = midi_busy_q;
  assign midi_ovf       = midi_ovf_q;
  assign host_ack       = host_ack_q;
  assign host_rdata     = host_rdata_q;
  assign adr            = adr_q;
  assign write          = write_q;
  assign read           = read_q;
  assign osc_sel        = sel_q[0];
  assign com_sel        = sel_q[1];
  assign m1_sel         = sel_q[2];
  assign m2_sel         = sel_q[3];
  assign synth_data_out = wdata_q;

`ifdef MIXER_ARB_DUMP_EN
  assign dump_valid = dump_valid_q;
  assign dump_data  = dump_data_q;
  assign dump_done  = dump_done_q;
`else
  logic unused_dump_start_s;
  assign unused_dump_start_s = dump_start;
  assign dump_valid = 1'b0;
  assign dump_data  = 8'd0;
  assign dump_done  = 1'b0;
`endif

endmodule

// File: tb/tb_mixer_reg_arbiter.sv
// Bench for mixer_reg_arbiter (default build): transaction-level reference model,
// behavioural register file on negedge, directed scenarios then randomized traffic.
module tb_mixer_reg_arbiter;

  logic       reg_clk = 1'b0;
  logic       reset;
  logic       midi_req;
  logic [1:0] midi_bank;
  logic [6:0] midi_adr;
  logic [7:0] midi_data;
  logic       midi_busy, midi_ovf;
  logic       host_req, host_wr;
  logic [1:0] host_bank;
  logic [6:0] host_adr;
  logic [7:0] host_wdata;
  logic       host_ack;
  logic [7:0] host_rdata;
  logic [6:0] adr;
  logic       write, read, osc_sel, com_sel, m1_sel, m2_sel;
  logic [7:0] synth_data_out;
  logic [7:0] mixer_regdata_out = 8'h00;
  logic       dump_start;
  logic       dump_valid, dump_done;
  logic [7:0] dump_data;

  int n_vec = 0;
  int n_bad = 0;

  mixer_reg_arbiter dut (
    .reg_clk(reg_clk), .reset(reset),
    .midi_req(midi_req), .midi_bank(midi_bank), .midi_adr(midi_adr), .midi_data(midi_data),
    .midi_busy(midi_busy), .midi_ovf(midi_ovf),
    .host_req(host_req), .host_wr(host_wr), .host_bank(host_bank), .host_adr(host_adr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .adr(adr), .write(write), .read(read),
    .osc_sel(osc_sel), .com_sel(com_sel), .m1_sel(m1_sel), .m2_sel(m2_sel),
    .synth_data_out(synth_data_out), .mixer_regdata_out(mixer_regdata_out),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_data(dump_data), .dump_done(dump_done)
  );

  always #5 reg_clk = ~reg_clk;

  // Register file environment: 4 banks x 128 bytes, reacts on negedge.
  logic [7:0] rf_mem [512];
  function automatic logic [1:0] sel_bank(input logic [3:0] s);
    if (s[3]) return 2'd3;
    else if (s[2]) return 2'd2;
    else if (s[1]) return 2'd1;
    else return 2'd0;
  endfunction

  always @(negedge reg_clk) begin
    if (write) rf_mem[{sel_bank({m2_sel, m1_sel, com_sel, osc_sel}), adr}] <= synth_data_out;
    if (read) mixer_regdata_out <= rf_mem[{sel_bank({m2_sel, m1_sel, com_sel, osc_sel}), adr}];
  end

  // Reference model: one transfer record plus the cycle count since its grant.
  logic [7:0] m_mem [512];
  bit         m_full, m_ovf, m_host_turn;
  logic [1:0] m_bbank;
  logic [6:0] m_badr;
  logic [7:0] m_bdata;
  bit         m_rec, m_rec_host, m_rec_rd;
  logic [1:0] m_rec_bank;
  int         m_c;
  logic [6:0] e_adr;
  logic [7:0] e_wdata, e_rdata;

  task automatic model_edge();
    bit idle, ack_now, host_p, midi_p, drain, take_host;
    if (reset) begin
      m_full = 0; m_ovf = 0; m_host_turn = 1; m_rec = 0; m_c = 0;
      e_adr = 7'd0; e_wdata = 8'd0; e_rdata = 8'd0;
    end else begin
      idle    = !m_rec || (!m_rec_rd && m_c >= 2) || (m_rec_rd && m_c >= 3);
      ack_now = m_rec && m_rec_host && (m_c == 2);
      host_p  = host_req && !ack_now;
      midi_p  = m_full;
      drain   = m_rec && !m_rec_host && (m_c == 1);
      if (m_rec) m_c++;
      if (idle && (host_p || midi_p)) begin
        take_host   = host_p && (!midi_p || m_host_turn);
        m_host_turn = !take_host;
        m_rec = 1; m_c = 1; m_rec_host = take_host;
        if (take_host) begin
          m_rec_rd = !host_wr; m_rec_bank = host_bank; e_adr = host_adr; e_wdata = host_wdata;
        end else begin
          m_rec_rd = 0; m_rec_bank = m_bbank; e_adr = m_badr; e_wdata = m_bdata;
        end
        if (!m_rec_rd) m_mem[{m_rec_bank, e_adr}] = e_wdata;
      end
      if (midi_req) begin
        if (!m_full || drain) begin
          m_full = 1; m_bbank = midi_bank; m_badr = midi_adr; m_bdata = midi_data;
        end else begin
          m_ovf = 1;
        end
      end else if (drain) begin
        m_full = 0;
      end
      if (m_rec && m_rec_host && m_rec_rd && m_c == 2) e_rdata = m_mem[{m_rec_bank, e_adr}];
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    bit   act1;
    logic [3:0] e_sel;
    act1  = m_rec && (m_c == 1);
    e_sel = act1 ? (4'b0001 << m_rec_bank) : 4'b0000;
    chk("write", {7'd0, write}, {7'd0, act1 && !m_rec_rd});
    chk("read", {7'd0, read}, {7'd0, act1 && m_rec_rd});
    chk("sel", {4'd0, m2_sel, m1_sel, com_sel, osc_sel}, {4'd0, e_sel});
    chk("adr", {1'b0, adr}, {1'b0, e_adr});
    chk("synth_data_out", synth_data_out, e_wdata);
    chk("host_ack", {7'd0, host_ack}, {7'd0, m_rec && m_rec_host && (m_c == 2)});
    chk("host_rdata", host_rdata, e_rdata);
    chk("midi_busy", {7'd0, midi_busy}, {7'd0, m_full});
    chk("midi_ovf", {7'd0, midi_ovf}, {7'd0, m_ovf});
    chk("dump_out", {6'd0, dump_valid, dump_done} | dump_data, 8'd0);
  endtask

  task automatic step();
    model_edge();
    @(posedge reg_clk);
    #1;
    compare_all();
  endtask

  task automatic new_host();
    host_req = 1'b1; host_wr = 1'($urandom_range(1, 0));
    host_bank = 2'($urandom_range(3, 0)); host_adr = 7'($urandom_range(127, 0));
    host_wdata = 8'($urandom_range(255, 0));
  endtask

  initial begin
    logic [7:0] v;
    for (int i = 0; i < 512; i++) begin
      v = 8'($urandom_range(255, 0));
      rf_mem[i] = v; m_mem[i] = v;
    end
    rf_mem[{2'd0, 7'h12}] = 8'h40; m_mem[{2'd0, 7'h12}] = 8'h40;
    reset = 1'b1; midi_req = 1'b0; midi_bank = 2'd0; midi_adr = 7'd0; midi_data = 8'd0;
    host_req = 1'b0; host_wr = 1'b0; host_bank = 2'd0; host_adr = 7'd0; host_wdata = 8'd0;
    dump_start = 1'b0;
    step(); step();
    chk("rst_adr", {1'b0, adr}, 8'h00);
    reset = 1'b0;

    // MIDI write com bank adr 1 data 0x55
    midi_req = 1'b1; midi_bank = 2'd1; midi_adr = 7'd1; midi_data = 8'h55; step();
    midi_req = 1'b0;
    chk("t1_busy", {7'd0, midi_busy}, 8'h01);
    step();
    chk("t1_write", {7'd0, write}, 8'h01); chk("t1_com", {7'd0, com_sel}, 8'h01);
    chk("t1_adr", {1'b0, adr}, 8'h01); chk("t1_data", synth_data_out, 8'h55);
    step();
    chk("t1_once", {7'd0, write}, 8'h00); chk("t1_drained", {7'd0, midi_busy}, 8'h00);
    step();

    // Host read osc 0x12 returning 0x40
    host_req = 1'b1; host_wr = 1'b0; host_bank = 2'd0; host_adr = 7'h12; step();
    chk("t2_read", {7'd0, read}, 8'h01); chk("t2_osc", {7'd0, osc_sel}, 8'h01);
    step();
    chk("t2_ack", {7'd0, host_ack}, 8'h01); chk("t2_rdata", host_rdata, 8'h40);
    chk("t2_read_low", {7'd0, read}, 8'h00);
    host_req = 1'b0; step();

    // Overflow: second midi_req while the buffer is full
    midi_req = 1'b1; midi_bank = 2'd2; midi_adr = 7'h33; midi_data = 8'hA5; step();
    midi_bank = 2'd3; midi_adr = 7'h44; midi_data = 8'h11; step();
    midi_req = 1'b0;
    chk("t4_ovf", {7'd0, midi_ovf}, 8'h01); chk("t4_m1", {7'd0, m1_sel}, 8'h01);
    chk("t4_adr", {1'b0, adr}, 8'h33); chk("t4_data", synth_data_out, 8'hA5);
    step(); step();
    chk("t4_ovf_sticky", {7'd0, midi_ovf}, 8'h01); chk("t4_empty", {7'd0, midi_busy}, 8'h00);

    // Host and MIDI in the same cycle: host goes first
    host_req = 1'b1; host_wr = 1'b1; host_bank = 2'd3; host_adr = 7'd5; host_wdata = 8'h77;
    midi_req = 1'b1; midi_bank = 2'd0; midi_adr = 7'd6; midi_data = 8'h88; step();
    midi_req = 1'b0;
    chk("t3_host_first", {1'b0, adr}, 8'h05); chk("t3_m2", {7'd0, m2_sel}, 8'h01);
    step();
    chk("t3_ack", {7'd0, host_ack}, 8'h01);
    host_req = 1'b0; step();
    chk("t3_midi_next", {1'b0, adr}, 8'h06); chk("t3_osc", {7'd0, osc_sel}, 8'h01);
    step();

    // Reset during RD aborts the read, held request is re-granted
    host_req = 1'b1; host_wr = 1'b0; host_bank = 2'd1; host_adr = 7'd7; step();
    chk("t5_rd", {7'd0, read}, 8'h01);
    reset = 1'b1; step();
    chk("t5_read_low", {7'd0, read}, 8'h00); chk("t5_no_ack", {7'd0, host_ack}, 8'h00);
    chk("t5_ovf_clr", {7'd0, midi_ovf}, 8'h00);
    reset = 1'b0; step();
    chk("t5_regrant", {7'd0, read}, 8'h01); chk("t5_com", {7'd0, com_sel}, 8'h01);
    step();
    chk("t5_ack", {7'd0, host_ack}, 8'h01);
    host_req = 1'b0; step();

    // Randomized mixed traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(299, 0) == 0);
      midi_req = ($urandom_range(99, 0) < 20);
      midi_bank = 2'($urandom_range(3, 0)); midi_adr = 7'($urandom_range(127, 0));
      midi_data = 8'($urandom_range(255, 0));
      dump_start = ($urandom_range(99, 0) < 5);
      step();
      if (host_ack) begin
        if ($urandom_range(1, 0) == 0) host_req = 1'b0;
        else new_host();
      end else if (!host_req && $urandom_range(99, 0) < 30) begin
        new_host();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
